// File: rtl/bcd_pkg.sv
// Shared types and constants for the four-digit BCD counter.
// Also holds the helper that maps any out-of-range nibble to a legal digit.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX    = 4'd9;
  localparam bcd_digit_t BCD_MIN    = 4'd0;
  localparam int         NUM_DIGITS = 4;

  // A nibble above 9 would make the downstream decoder show a hex letter.
  // Such a nibble is therefore forced to zero.
  function automatic bcd_digit_t bcd_sanitize(input logic [3:0] nib);
    return (nib > BCD_MAX) ? BCD_MIN : bcd_digit_t'(nib);
  endfunction

endpackage

// File: rtl/bcd_counter_4d_if.sv
// Control and status bundle between the BCD counter and its host logic.
// The host side drives the master modport and the counter uses the slave modport.
interface bcd_counter_4d_if;
  import bcd_pkg::*;

  logic                      en;
  logic                      up_dn;
  logic                      clear;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   load_val;
  logic [4*NUM_DIGITS-1:0]   bcd_out;
  logic                      tick;
  logic                      wrap;
  logic [NUM_DIGITS-1:0]     digit_blank;

  modport master (
    output en, up_dn, clear, load, load_val,
    input  bcd_out, tick, wrap, digit_blank
  );

  modport slave (
    input  en, up_dn, clear, load, load_val,
    output bcd_out, tick, wrap, digit_blank
  );

endinterface

// File: rtl/bcd_digit_cell.sv
// Single BCD digit step: applies +1/-1 when step_in is set and reports carry/borrow.
// Purely combinational; the top owns the digit registers.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  bcd_digit_t digit_cur,
  input  logic       up_dn,
  input  logic       step_in,
  output bcd_digit_t digit_nxt,
  output logic       step_out
);

  always_comb begin
    digit_nxt = digit_cur;
    step_out  = 1'b0;
    if (step_in) begin
      if (up_dn) begin
        if (digit_cur >= BCD_MAX) begin
          digit_nxt = BCD_MIN;
          step_out  = 1'b1;
        end else begin
          digit_nxt = digit_cur + 4'd1;
        end
      end else begin
        if (digit_cur == BCD_MIN) begin
          digit_nxt = BCD_MAX;
          step_out  = 1'b1;
        end else begin
          digit_nxt = digit_cur - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and strobes tick on the terminal count.
// sync_rst returns the count to 0 regardless of en.
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sync_rst,
  output logic tick
);

  localparam int               CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = en && (cnt_q == TERM);
    if (sync_rst) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bcd_counter_4d.sv
// Four-digit BCD up/down counter with prescaler, load/clear and wrap flag.
// Leading-zero blanking is built only when BCD_COUNTER_4D_BLANK_EN is defined.
module bcd_counter_4d
  import bcd_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TICK_HZ  = 1
) (
  input logic               clk,
  input logic               rst_n,
  bcd_counter_4d_if.slave   bus
);

  localparam int DIV = CLK_FREQ / TICK_HZ;

  bcd_digit_t [NUM_DIGITS-1:0] digits_q, digits_d;
  bcd_digit_t [NUM_DIGITS-1:0] digits_nxt;
  logic       [NUM_DIGITS:0]   step_c;
  logic                        wrap_q, wrap_d;
  logic                        tick_w;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bus.en),
    .sync_rst (bus.clear | bus.load),
    .tick     (tick_w)
  );

  // tick_w is already qualified by en, so it alone starts the ripple.
  assign step_c[0] = tick_w;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    bcd_digit_cell u_cell (
      .digit_cur (digits_q[gi]),
      .up_dn     (bus.up_dn),
      .step_in   (step_c[gi]),
      .digit_nxt (digits_nxt[gi]),
      .step_out  (step_c[gi+1])
    );
  end

  always_comb begin
    digits_d = digits_q;
    wrap_d   = 1'b0;
    if (bus.clear) begin
      digits_d = '0;
    end else if (bus.load) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digits_d[i] = bcd_sanitize(bus.load_val[4*i +: 4]);
      end
    end else if (step_c[0]) begin
      digits_d = digits_nxt;
      wrap_d   = step_c[NUM_DIGITS];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      digits_q <= digits_d;
      wrap_q   <= wrap_d;
    end
  end

  assign bus.bcd_out = digits_q;
  assign bus.tick    = tick_w;
  assign bus.wrap    = wrap_q;

`ifdef BCD_COUNTER_4D_BLANK_EN
  localparam logic [NUM_DIGITS-1:0] BLANK_RST = {{(NUM_DIGITS-1){1'b1}}, 1'b0};

  logic [NUM_DIGITS-1:0] blank_q, blank_d;

  // Derived from the next digit value so the mask lands on the same edge as bcd_out.
  always_comb begin
    logic zero_run;
    blank_d  = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run & (digits_d[i] == BCD_MIN);
      blank_d[i] = zero_run;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= BLANK_RST;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign bus.digit_blank = blank_q;
`else
  assign bus.digit_blank = '0;
`endif

endmodule

// File: tb/tb_bcd_counter_4d.sv
// Directed bench for bcd_counter_4d with CLK_FREQ=10, TICK_HZ=1 (prescaler period 10).
// Expected blanking follows BCD_COUNTER_4D_BLANK_EN when it is defined for the build.
module tb_bcd_counter_4d;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;

  bcd_counter_4d_if bus ();

  bcd_counter_4d #(
    .CLK_FREQ (10),
    .TICK_HZ  (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_blank(input logic [15:0] v);
`ifdef BCD_COUNTER_4D_BLANK_EN
    logic [3:0] b;
    b[3] = (v[15:12] == 4'd0);
    b[2] = b[3] & (v[11:8] == 4'd0);
    b[1] = b[2] & (v[7:4] == 4'd0);
    b[0] = 1'b0;
    return b;
`else
    return (v == 16'hFFFF) ? 4'b0000 : 4'b0000;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_val(input string tag, input logic [15:0] v);
    chk(tag, {16'd0, bus.bcd_out}, {16'd0, v});
    chk({tag, "_blank"}, {28'd0, bus.digit_blank}, {28'd0, exp_blank(v)});
  endtask

  // Steps until tick is seen; n returns the number of steps taken.
  task automatic run_to_tick(input string tag, output int n);
    n = 0;
    while (bus.tick !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    if (bus.tick !== 1'b1) chk({tag, "_tick_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.load     = 1'b1;
    bus.load_val = v;
    step();
    bus.load     = 1'b0;
  endtask

  initial begin
    int n;
    int ticks;
    int first_tick;
    int wraps;

    n_chk        = 0;
    n_bad        = 0;
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.up_dn    = 1'b1;
    bus.clear    = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = 16'h0000;

    // Reset state.
    step();
    step();
    chk_val("rst_bcd", 16'h0000);
    chk("rst_tick", {31'd0, bus.tick}, 32'd0);
    chk("rst_wrap", {31'd0, bus.wrap}, 32'd0);
`ifdef BCD_COUNTER_4D_BLANK_EN
    chk("rst_blank_val", {28'd0, bus.digit_blank}, 32'hE);
`endif
    rst_n = 1'b1;
    step();

    // Free run: 100 clocks, ticks every 10.
    bus.en     = 1'b1;
    ticks      = 0;
    first_tick = -1;
    wraps      = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (bus.tick === 1'b1) begin
        ticks++;
        if (first_tick < 0) first_tick = i;
        chk("tick_phase", i % 10, 9);
      end
      if (bus.wrap === 1'b1) wraps++;
    end
    chk("run_ticks", ticks, 10);
    chk("run_first_tick", first_tick, 9);
    chk("run_wraps", wraps, 0);
    chk_val("run_bcd", 16'h0010);

    // Up overflow 9999 -> 0000.
    do_load(16'h9998);
    chk_val("up_load", 16'h9998);
    run_to_tick("up1", n);
    chk("up1_interval", n, 9);
    step();
    chk_val("up1_bcd", 16'h9999);
    chk("up1_wrap", {31'd0, bus.wrap}, 32'd0);
    run_to_tick("up2", n);
    step();
    chk_val("up2_bcd", 16'h0000);
    chk("up2_wrap", {31'd0, bus.wrap}, 32'd1);
    step();
    chk("up2_wrap_end", {31'd0, bus.wrap}, 32'd0);

    // Down underflow 0000 -> 9999.
    bus.up_dn = 1'b0;
    do_load(16'h0001);
    chk_val("dn_load", 16'h0001);
    run_to_tick("dn1", n);
    step();
    chk_val("dn1_bcd", 16'h0000);
    chk("dn1_wrap", {31'd0, bus.wrap}, 32'd0);
    run_to_tick("dn2", n);
    step();
    chk_val("dn2_bcd", 16'h9999);
    chk("dn2_wrap", {31'd0, bus.wrap}, 32'd1);
    step();
    chk("dn2_wrap_end", {31'd0, bus.wrap}, 32'd0);

    // Illegal nibbles load as zero; clear beats load.
    do_load(16'h0A5F);
    chk_val("sanitize", 16'h0050);
    bus.clear    = 1'b1;
    bus.load     = 1'b1;
    bus.load_val = 16'h1234;
    step();
    bus.clear = 1'b0;
    bus.load  = 1'b0;
    chk_val("clr_wins", 16'h0000);
    chk("clr_tick", {31'd0, bus.tick}, 32'd0);
    chk("clr_wrap", {31'd0, bus.wrap}, 32'd0);

    // Pause at prescaler=4 for 20 cycles.
    for (int i = 0; i < 4; i++) step();
    bus.en = 1'b0;
    ticks  = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.tick === 1'b1) ticks++;
    end
    chk("pause_ticks", ticks, 0);
    chk_val("pause_hold", 16'h0000);
    bus.en    = 1'b1;
    bus.up_dn = 1'b1;
    run_to_tick("resume", n);
    chk("resume_delay", n, 5);
    step();
    chk_val("resume_bcd", 16'h0001);

    // Direction changed in the tick cycle itself takes effect.
    run_to_tick("dirsw", n);
    bus.up_dn = 1'b0;
    step();
    chk_val("dirsw_bcd", 16'h0000);
    chk("dirsw_wrap", {31'd0, bus.wrap}, 32'd0);

    // Blank mask on partial value and after clear.
    do_load(16'h0040);
    chk_val("blank_0040", 16'h0040);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk_val("blank_clr", 16'h0000);

    // Asynchronous reset mid-count.
    do_load(16'h1234);
    for (int i = 0; i < 6; i++) step();
    chk_val("pre_rst", 16'h1234);
    #3;
    rst_n = 1'b0;
    #1;
    chk_val("async_rst_bcd", 16'h0000);
    chk("async_rst_tick", {31'd0, bus.tick}, 32'd0);
    chk("async_rst_wrap", {31'd0, bus.wrap}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
